// File: rtl/led_pkg.sv
// Shared types and constants for the LED serial link receiver.
package led_pkg;

  // Receiver FSM: waiting for a frame, or collecting bits of a frame.
  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_e;

  // Word width shared with the LED_send transmitter.
  localparam int LED_DATA_W = 128;

  // Default number of words expected per frame.
  localparam int LED_NUM_DEF = 4;

  // 8-bit increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/led_recv_if.sv
// Output bundle of the LED link receiver.
//
// Handshake: data_valid and frame_done are single-cycle strobes with no
// back-pressure (there is no ready). A consumer must sample data_out and
// word_idx in the cycle data_valid is high, and word_cnt / frame_err in the
// cycle frame_done is high. The two strobes are never high together.
interface led_recv_if
  import led_pkg::*;
#(
  parameter int DATA_W = LED_DATA_W
);
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [7:0]        word_idx;
  logic              frame_done;
  logic              frame_err;
  logic [7:0]        word_cnt;
  rx_state_e         state;

  modport master (
    output data_out, data_valid, word_idx, frame_done, frame_err, word_cnt, state
  );

  modport slave (
    input data_out, data_valid, word_idx, frame_done, frame_err, word_cnt, state
  );
endinterface

// File: rtl/led_sync_edge.sv
// Synchronizes cko/sdo into clk through identical flop chains so the two stay
// aligned, and flags a cko rising edge for one clk cycle.
module led_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic cko_i,
  input  logic sdo_i,
  output logic cko_rise,
  output logic sdo_s
);

  logic [SYNC_STAGES-1:0] cko_sr;
  logic [SYNC_STAGES-1:0] sdo_sr;
  logic                   cko_s;
  logic                   cko_d;

  assign cko_s    = cko_sr[SYNC_STAGES-1];
  assign sdo_s    = sdo_sr[SYNC_STAGES-1];
  assign cko_rise = cko_s & ~cko_d;

  // Synchronizer chains plus one delay stage on cko for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      cko_sr <= '0;
      sdo_sr <= '0;
      cko_d  <= 1'b0;
    end else begin
      cko_sr <= {cko_sr[SYNC_STAGES-2:0], cko_i};
      sdo_sr <= {sdo_sr[SYNC_STAGES-2:0], sdo_i};
      cko_d  <= cko_s;
    end
  end

endmodule

// File: rtl/led_recv.sv
// LED link receiver: shifts sdo in on each cko rising edge, rebuilds DATA_W
// bit words (MSB first) and delimits frames by an idle gap on cko.
module led_recv
  import led_pkg::*;
#(
  parameter int DATA_W      = LED_DATA_W,
  parameter int LED_NUM     = LED_NUM_DEF,
  parameter int IDLE_CNT    = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk,
  input  logic     rstn,
  input  logic     cko_i,
  input  logic     sdo_i,
  led_recv_if.master rx
);

  localparam int BW = $clog2(DATA_W);
  localparam int IW = $clog2(IDLE_CNT + 1);

  logic              cko_rise;
  logic              sdo_s;
  rx_state_e         state;
  rx_state_e         state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic [IW-1:0]     idle_cnt;
  logic [7:0]        wcnt;
  logic              word_pend;
  logic              last_bit;
  logic              idle_hit;
  logic              frame_end;

  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [7:0]        word_idx;
  logic              frame_done;
  logic              frame_err;
  logic [7:0]        word_cnt;

  led_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rstn),
    .cko_i    (cko_i),
    .sdo_i    (sdo_i),
    .cko_rise (cko_rise),
    .sdo_s    (sdo_s)
  );

  assign last_bit = (bit_cnt == BW'(DATA_W - 1));
  assign idle_hit = (idle_cnt == IW'(IDLE_CNT));
  // An edge or a pending word completion both postpone the frame end.
  assign frame_end = (state == RECV) && idle_hit && !cko_rise && !word_pend;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rstn) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cko_rise)  state_nxt = RECV;
      RECV: if (frame_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register, counters and registered output strobes.
  always_ff @(posedge clk) begin
    if (rstn) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      idle_cnt   <= '0;
      wcnt       <= '0;
      word_pend  <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      word_idx   <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      word_cnt   <= '0;
    end else begin
      data_valid <= 1'b0;
      frame_done <= 1'b0;

      if (cko_rise) shreg <= {shreg[DATA_W-2:0], sdo_s};

      // Publish a completed word one cycle after its last bit was shifted in.
      if (word_pend) begin
        word_pend  <= 1'b0;
        data_out   <= shreg;
        data_valid <= 1'b1;
        word_idx   <= wcnt;
        wcnt       <= sat_inc8(wcnt);
      end

      case (state)
        IDLE: begin
          bit_cnt  <= cko_rise ? BW'(1) : '0;
          idle_cnt <= '0;
          wcnt     <= '0;
        end
        RECV: begin
          if (cko_rise) begin
            idle_cnt <= '0;
            if (last_bit) begin
              bit_cnt   <= '0;
              word_pend <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else if (!idle_hit) begin
            idle_cnt <= idle_cnt + IW'(1);
          end

          if (frame_end) begin
            frame_done <= 1'b1;
            word_cnt   <= wcnt;
            frame_err  <= (wcnt != 8'(LED_NUM)) || (bit_cnt != '0);
            bit_cnt    <= '0;
            idle_cnt   <= '0;
            wcnt       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rx.data_out   = data_out;
  assign rx.data_valid = data_valid;
  assign rx.word_idx   = word_idx;
  assign rx.frame_done = frame_done;
  assign rx.frame_err  = frame_err;
  assign rx.word_cnt   = word_cnt;
  assign rx.state      = state;

endmodule

// File: tb/tb_led_recv.sv
// Directed bench for led_recv: two receivers (LED_NUM=4 and LED_NUM=1) share
// one emulated LED_send link; a negedge monitor collects strobes into queues.
module tb_led_recv;
  import led_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic cko = 1'b0;
  logic sdo = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] exp_q[$];
  logic [127:0] got_w[$];
  logic [7:0]   got_i[$];
  logic [7:0]   f_cnt[$];
  logic         f_err[$];
  logic         f1_err[$];

  logic [127:0] w0 = 128'h0123456789ABCDEF_FEDCBA9876543210;
  logic [127:0] w1 = 128'hDEADBEEF_CAFEF00D_A5A5A5A5_5A5A5A5A;
  logic [127:0] w2 = 128'hFFFFFFFF_00000000_FFFFFFFF_00000000;
  logic [127:0] w3 = 128'h13579BDF_2468ACE0_0F0F0F0F_F0F0F0F0;
  logic [127:0] w4 = 128'h00000000_00000000_00000000_00000001;
  logic [127:0] wb = 128'h80000000_00000000_00000000_00000001;

  led_recv_if #(.DATA_W(128)) rx4 ();
  led_recv_if #(.DATA_W(128)) rx1 ();

  led_recv #(.DATA_W(128), .LED_NUM(4), .IDLE_CNT(20), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .cko_i (cko),
    .sdo_i (sdo),
    .rx    (rx4.master)
  );

  led_recv #(.DATA_W(128), .LED_NUM(1), .IDLE_CNT(20), .SYNC_STAGES(2)) dut1 (
    .clk   (clk),
    .rstn  (rstn),
    .cko_i (cko),
    .sdo_i (sdo),
    .rx    (rx1.master)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: record strobes away from the active edge.
  always @(negedge clk) begin
    if (rx4.data_valid) begin
      got_w.push_back(rx4.data_out);
      got_i.push_back(rx4.word_idx);
      chk("excl_strobes", 128'(rx4.frame_done), 128'(0));
    end
    if (rx4.frame_done) begin
      f_cnt.push_back(rx4.word_cnt);
      f_err.push_back(rx4.frame_err);
    end
    if (rx1.frame_done) f1_err.push_back(rx1.frame_err);
  end

  // Driver tasks (all timing aligned to clk negedge)
  task automatic send_bit(input logic b, input int half);
    sdo = b;
    cko = 1'b0;
    repeat (half) @(negedge clk);
    cko = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  task automatic send_word(input logic [127:0] w, input int half);
    for (int i = 127; i >= 0; i--) send_bit(w[i], half);
  endtask

  task automatic idle(input int n);
    cko = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_q();
    exp_q.delete(); got_w.delete(); got_i.delete();
    f_cnt.delete(); f_err.delete(); f1_err.delete();
  endtask

  // Scoreboard: compare received words and indices against exp_q.
  task automatic check_words(input string t);
    int k;
    k = 0;
    chk({t, "_nwords"}, 128'(got_w.size()), 128'(exp_q.size()));
    while (exp_q.size() > 0 && got_w.size() > 0) begin
      chk($sformatf("%s_word%0d", t, k), got_w.pop_front(), exp_q.pop_front());
      chk($sformatf("%s_idx%0d", t, k), 128'(got_i.pop_front()), 128'(k));
      k++;
    end
  endtask

  task automatic check_frame(input string t, input int cnt, input logic err4, input logic err1);
    chk({t, "_nframes"}, 128'(f_cnt.size()), 128'(1));
    if (f_cnt.size() > 0) begin
      chk({t, "_word_cnt"}, 128'(f_cnt.pop_front()), 128'(cnt));
      chk({t, "_frame_err"}, 128'(f_err.pop_front()), 128'(err4));
    end
    chk({t, "_nframes1"}, 128'(f1_err.size()), 128'(1));
    if (f1_err.size() > 0) chk({t, "_frame_err1"}, 128'(f1_err.pop_front()), 128'(err1));
  endtask

  task automatic check_reset_outputs(input string t);
    chk({t, "_data_out"},   rx4.data_out, 128'(0));
    chk({t, "_data_valid"}, 128'(rx4.data_valid), 128'(0));
    chk({t, "_word_idx"},   128'(rx4.word_idx), 128'(0));
    chk({t, "_frame_done"}, 128'(rx4.frame_done), 128'(0));
    chk({t, "_frame_err"},  128'(rx4.frame_err), 128'(0));
    chk({t, "_word_cnt"},   128'(rx4.word_cnt), 128'(0));
    chk({t, "_state"},      128'(rx4.state), 128'(IDLE));
  endtask

  initial begin
    // Reset
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // 1: loopback-style frame of four words, half period 5
    clear_q();
    exp_q.push_back(w0); exp_q.push_back(w1); exp_q.push_back(w2); exp_q.push_back(w3);
    send_word(w0, 5); send_word(w1, 5); send_word(w2, 5); send_word(w3, 5);
    idle(40);
    check_words("t1");
    check_frame("t1", 4, 1'b0, 1'b1);

    // 2: single boundary word 0x8000...0001, 30+ cycle gap
    clear_q();
    exp_q.push_back(wb);
    send_word(wb, 3);
    idle(40);
    check_words("t2");
    check_frame("t2", 1, 1'b1, 1'b0);
    chk("t2_data_out", rx4.data_out, wb);

    // 3: two words plus a 17-bit partial word
    clear_q();
    exp_q.push_back(w2); exp_q.push_back(w1);
    send_word(w2, 3); send_word(w1, 3);
    for (int i = 127; i >= 111; i--) send_bit(w3[i], 3);
    idle(40);
    check_words("t3");
    check_frame("t3", 2, 1'b1, 1'b1);
    chk("t3_data_out_hold", rx4.data_out, w1);

    // 4: five words with LED_NUM=4
    clear_q();
    exp_q.push_back(w0); exp_q.push_back(w1); exp_q.push_back(w2);
    exp_q.push_back(w3); exp_q.push_back(w4);
    send_word(w0, 3); send_word(w1, 3); send_word(w2, 3); send_word(w3, 3); send_word(w4, 3);
    idle(40);
    check_words("t4");
    check_frame("t4", 5, 1'b1, 1'b1);

    // 5: 20-cycle rise-to-rise pause mid-word must not end the frame
    clear_q();
    exp_q.push_back(w3);
    for (int i = 127; i >= 0; i--) begin
      if (i == 70) begin
        sdo = w3[i];
        cko = 1'b0;
        repeat (17) @(negedge clk);
        cko = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_no_frame_in_pause", 128'(f_cnt.size()), 128'(0));
      end else begin
        send_bit(w3[i], 3);
      end
    end
    idle(40);
    check_words("t5");
    check_frame("t5", 1, 1'b1, 1'b0);

    // 6: reset after bit 60 of word 1, then a fresh frame
    clear_q();
    send_word(w0, 3);
    for (int i = 127; i >= 67; i--) send_bit(w1[i], 3);
    idle(3);
    rstn = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check_reset_outputs("t6_rst");
    clear_q();
    idle(40);
    chk("t6_no_abort_frame", 128'(f_cnt.size()), 128'(0));
    exp_q.push_back(w3); exp_q.push_back(w2); exp_q.push_back(w1); exp_q.push_back(w0);
    send_word(w3, 3); send_word(w2, 3); send_word(w1, 3); send_word(w0, 3);
    idle(40);
    check_words("t6");
    check_frame("t6", 4, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
